room_plant: RTL



---
 rtl/room_plant.sv | 124 ++++++++++++
 1 files changed

// File: rtl/room_plant.sv
// room_plant: behavioural thermal plant for closed-loop thermostat benches.
// The temperature rises while heating, falls while cooling and drifts toward
// T_AMB when neither command is active. Each mode has its own step rate.
module room_plant #(
  parameter logic [4:0]  T_INIT    = 5'd25,
  parameter logic [4:0]  T_AMB     = 5'd20,
  parameter int unsigned HEAT_DIV  = 4,
  parameter int unsigned COOL_DIV  = 4,
  parameter int unsigned DRIFT_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       heat_i,
  input  logic       cool_i,
  input  logic       ld_i,
  input  logic [4:0] ld_val_i,
  output logic [4:0] troom_o,
  output logic       step_o,
  output logic       conflict_o
);

  typedef enum logic [1:0] {
    DRIFT,
    HEAT,
    COOL
  } mode_t;

  // Terminal counts; a DIV of 256 maps onto 8'hFF, so cnt never overflows.
  localparam logic [7:0] HEAT_LAST  = 8'(HEAT_DIV - 1);
  localparam logic [7:0] COOL_LAST  = 8'(COOL_DIV - 1);
  localparam logic [7:0] DRIFT_LAST = 8'(DRIFT_DIV - 1);

  mode_t      mode_q;
  mode_t      mode_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_last;
  logic [4:0] troom_q;
  logic [4:0] troom_d;
  logic [4:0] troom_step;
  logic       step_d;

  // Mode register: follows the decoded command every edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= DRIFT;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Command decode: both or neither command active means drift.
  always_comb begin
    mode_d = DRIFT;
    if (heat_i && !cool_i) begin
      mode_d = HEAT;
    end else if (cool_i && !heat_i) begin
      mode_d = COOL;
    end
  end

  // Rate selection and the saturating target temperature for the current mode.
  always_comb begin
    cnt_last   = DRIFT_LAST;
    troom_step = troom_q;
    unique case (mode_q)
      HEAT: begin
        cnt_last = HEAT_LAST;
        if (troom_q != 5'd31) begin
          troom_step = troom_q + 5'd1;
        end
      end
      COOL: begin
        cnt_last = COOL_LAST;
        if (troom_q != 5'd0) begin
          troom_step = troom_q - 5'd1;
        end
      end
      default: begin
        if (troom_q < T_AMB) begin
          troom_step = troom_q + 5'd1;
        end else if (troom_q > T_AMB) begin
          troom_step = troom_q - 5'd1;
        end
      end
    endcase
  end

  // Next-state datapath: load, then mode-change clear, then step, then count.
  always_comb begin
    cnt_d   = cnt_q + 8'd1;
    troom_d = troom_q;
    step_d  = 1'b0;
    if (ld_i) begin
      cnt_d   = '0;
      troom_d = ld_val_i;
    end else if (mode_d != mode_q) begin
      cnt_d = '0;
    end else if (cnt_q == cnt_last) begin
      // A blocked step (saturated or at ambient) still restarts the count.
      cnt_d   = '0;
      troom_d = troom_step;
      step_d  = (troom_step != troom_q);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      troom_q    <= T_INIT;
      step_o     <= 1'b0;
      conflict_o <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      troom_q    <= troom_d;
      step_o     <= step_d;
      conflict_o <= heat_i & cool_i;
    end
  end

  assign troom_o = troom_q;

endmodule
